// File: rtl/imem_loader_if.sv
// Write bus and status lines between the serial boot loader and the instruction memory / CPU.
// The loader is the master. The memory/CPU side, or a bench, is the slave and drives rx.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (input rx, output wr_en, wr_addr, wr_data, cpu_hold, done, err);
  modport slave  (output rx, input wr_en, wr_addr, wr_data, cpu_hold, done, err);
endinterface

// File: rtl/imem_loader.sv
// UART (8N1) boot loader: reads a 16-bit little-endian word count, then packs the following
// bytes into 32-bit words written from address 0. The CPU is held in reset until the image is done.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN0, L_LEN1, L_DATA, L_DONE} ld_state_t;

  rx_state_t         rx_state, rx_state_next;
  ld_state_t         ld_state, ld_state_next;
  logic              sync1, rxs;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              sample, byte_valid, frame_err;
  logic [7:0]        len_lo;
  logic [15:0]       len, len_full;
  logic              len_over, last_word;
  logic [ADDR_W:0]   wptr;
  logic [1:0]        idx;
  logic [23:0]       word;
  logic              wr_en_reg, err_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;

  // Both synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rxs   <= sync1;
    end
  end

  assign sample = (rx_state == RX_START && cnt == CW'(HALF - 1)) ||
                  ((rx_state == RX_DATA || rx_state == RX_STOP) && cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rxs) rx_state_next = RX_START;
      RX_START: if (sample) rx_state_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample && bit_idx == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (sample) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= (rx_state == RX_STOP) && sample && rxs;
      frame_err  <= (rx_state == RX_STOP) && sample && !rxs;
      if (rx_state == RX_IDLE || sample) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && sample) begin
        shift   <= {rxs, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // shift still holds the completed byte while byte_valid is high.
  assign len_full  = {shift, len_lo};
  assign len_over  = 32'(len_full) > 32'(DEPTH);
  assign last_word = (16'(wptr + 1'b1) == len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ld_state <= L_LEN0;
    else     ld_state <= ld_state_next;
  end

  always_comb begin
    ld_state_next = ld_state;
    case (ld_state)
      L_LEN0: if (byte_valid) ld_state_next = L_LEN1;
      L_LEN1: if (byte_valid) begin
        if (len_full == 16'd0) ld_state_next = L_DONE;
        else if (len_over)     ld_state_next = L_LEN0;
        else                   ld_state_next = L_DATA;
      end
      L_DATA: if (byte_valid && idx == 2'd3 && last_word) ld_state_next = L_DONE;
      default: ld_state_next = ld_state;
    endcase
    if (frame_err && ld_state != L_DONE) ld_state_next = L_LEN0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo      <= '0;
      len         <= '0;
      wptr        <= '0;
      idx         <= '0;
      word        <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      if (frame_err && ld_state != L_DONE) err_reg <= 1'b1;
      if (byte_valid) begin
        case (ld_state)
          L_LEN0: len_lo <= shift;
          L_LEN1: begin
            len  <= len_full;
            wptr <= '0;
            idx  <= '0;
            if (len_over) err_reg <= 1'b1;
          end
          L_DATA: begin
            // Bytes enter from the top so the first byte ends up in bits 7:0 of the word.
            word <= {shift, word[23:8]};
            idx  <= idx + 1'b1;
            if (idx == 2'd3) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= wptr[ADDR_W-1:0];
              wr_data_reg <= {shift, word};
              wptr        <= wptr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.err      = err_reg;
  assign bus.cpu_hold = (ld_state != L_DONE);
  assign bus.done     = (ld_state == L_DONE);
endmodule

// File: doc/imem_loader.md
# imem_loader

Serial boot loader that fills the pipeline's word-addressed instruction memory. It receives a UART byte stream (8N1, LSB first), checks a 16-bit word-count header and packs the following bytes into 32-bit little-endian words. Each word is written to consecutive instruction-memory addresses starting at 0. It holds the processor's PC in reset (`cpu_hold`) until the image is complete, then releases it.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `ADDR_W`, 8, instruction-memory word-address width.
- `DEPTH`, 256, instruction-memory size in words; must be ≤ 2^ADDR_W.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: UART serial line; idles high; asynchronous to `clk`.
- `wr_en` output 1: one-cycle instruction-memory write strobe.
- `wr_addr` output ADDR_W: word address for the current write.
- `wr_data` output 32: instruction word for the current write.
- `cpu_hold` output 1: high keeps the PC in reset; drives the processor's `pc_rst`.
- `done` output 1: image loaded; stays high until the next reset.
- `err` output 1: sticky error flag (framing error or oversize length); cleared only by `rst`.

## Operation
- `rx` passes through a 2-flop synchronizer. All decoding uses the synchronized value `rxs`.
- Byte receiver FSM:
  - RX_IDLE → RX_START on `rxs` = 0.
  - RX_START: count `CLKS_PER_BIT/2` cycles (integer division), then sample.
    - If `rxs` = 1, it is a false start: return to RX_IDLE with no byte.
    - Otherwise go to RX_DATA.
  - RX_DATA: sample 8 bits, one every `CLKS_PER_BIT` cycles, LSB first, into a shift register.
  - RX_STOP: sample once after `CLKS_PER_BIT` cycles.
    - `rxs` = 1: emit a one-cycle internal `byte_valid`.
    - `rxs` = 0: framing error. Set `err`, emit no byte, and reset the loader FSM to L_LEN0.
  - Then return to RX_IDLE.
- Loader FSM, advanced only on `byte_valid`:
  - L_LEN0: latch `len[7:0]` → L_LEN1.
  - L_LEN1: latch `len[15:8]`, then branch:
    - `len` = 0 → L_DONE.
    - `len` > DEPTH → set `err`, go to L_LEN0.
    - Otherwise clear the word pointer and byte index → L_DATA.
  - L_DATA: place the byte in `word[8*idx +: 8]`, where `idx` is 0..3 (first byte is bits 7:0).
    - When `idx` = 3: issue the write, `wptr++`, and `idx` returns to 0.
    - When `wptr` reaches `len`: go to L_DONE.
  - L_DONE: terminal until `rst`. All further `rx` activity is ignored and produces no writes.
- Outputs by state:
  - `cpu_hold` = 1 in every state except L_DONE.
  - `done` = 1 only in L_DONE.
- Width rules:
  - `wptr` is ADDR_W+1 bits so that `len` = DEPTH = 2^ADDR_W terminates correctly.
  - `wr_addr` = `wptr[ADDR_W-1:0]`.
- Partial words: a framing error inside L_DATA discards the partial word. Words already written stay in memory. The next valid bytes are interpreted as a new header.

## Timing
- Reset values (async, immediate):
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `cpu_hold` = 1, `done` = 0, `err` = 0.
  - Both FSMs in their idle/L_LEN0 state; synchronizer flops = 1.
- Input latency: the `rx` falling edge reaches `rxs` 2 cycles later.
- `byte_valid` fires 1 cycle after the stop-bit sample.
- Write timing:
  - `wr_en` pulses high for exactly 1 cycle, 1 cycle after the `byte_valid` of the 4th byte.
  - `wr_addr` and `wr_data` are registered and valid in the same cycle as `wr_en`.
  - They hold their values afterward.
- Release timing: `cpu_hold` falls and `done` rises in the same cycle as the final `wr_en`. For `len` = 0, this happens 1 cycle after the 2nd header byte's `byte_valid`.
- A byte that arrives back-to-back (start bit immediately after stop sample) must be received without loss.
- Reset asserted mid-byte or mid-image aborts immediately. No write occurs in the reset cycle. After deassertion, loading restarts from L_LEN0 with `wptr` = 0.

## Test plan
Use `CLKS_PER_BIT` = 4 and `DEPTH` = 256 for all scenarios.
- Reset: with `rst` held high, `cpu_hold` = 1 and `done`/`err`/`wr_en` = 0. After release and with `rx` = 1 for 100 cycles, no `wr_en`.
- Normal load: send bytes 02 00 13 05 A0 00 B3 05 B5 00 → two writes:
  - addr 0 = 0x00A00513;
  - addr 1 = 0x00B505B3.
  - `done` = 1 and `cpu_hold` = 0 in the cycle of the 2nd `wr_en`.
  - Extra bytes sent afterward produce no writes.
- Zero length: send 00 00 → `done` = 1 with no `wr_en` pulses.
- Oversize length: send 01 01 (257 words) → `err` = 1 and `cpu_hold` stays 1. Then send 01 00 + 4 bytes → 1 write at addr 0, `done` = 1, and `err` remains 1.
- Framing error mid-word:
  - Send 01 00 EF BE, then a byte with stop bit = 0 → `err` = 1 and no write.
  - Then send 01 00 78 56 34 12 → addr 0 = 0x12345678.
- Glitch and mid-load reset:
  - A 1-cycle low pulse on `rx` (false start) → no byte received.
  - Assert `rst` after 2 data bytes of a 1-word image → outputs return to reset values. A fresh full image then loads correctly.
